mod_wrap_counter: RTL

//  Parametrised modulo-N counter with a built-in terminal-count comparator and wrap detection.

---
 rtl/mod_wrap_counter_if.sv | 36 +++
 rtl/mod_wrap_counter.sv | 107 ++++++++++
 2 files changed

// File: rtl/mod_wrap_counter_if.sv
// Control/status bundle for one modulo-N counter stage.
// The wrap_cnt signal exists only when WRAP_COUNT_EN is defined.
interface mod_wrap_counter_if #(
    parameter int WIDTH = 3
);
    logic             clr;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             en;
    logic             up;
    logic [WIDTH-1:0] count;
    logic             wrap;
    logic             tc;
    logic             load_err;
`ifdef WRAP_COUNT_EN
    logic [7:0]       wrap_cnt;

    modport master (
        output clr, load, load_val, en, up,
        input  count, wrap, tc, load_err, wrap_cnt
    );
    modport slave (
        input  clr, load, load_val, en, up,
        output count, wrap, tc, load_err, wrap_cnt
    );
`else
    modport master (
        output clr, load, load_val, en, up,
        input  count, wrap, tc, load_err
    );
    modport slave (
        input  clr, load, load_val, en, up,
        output count, wrap, tc, load_err
    );
`endif
endinterface

// File: rtl/mod_wrap_counter.sv
// Modulo-MODULUS up/down counter stage with combinational terminal count for cascading.
// Optional feature macro WRAP_COUNT_EN adds a saturating 8-bit wrap tally (wrap_cnt).
module mod_wrap_counter #(
    parameter int WIDTH   = 3,
    parameter int MODULUS = 5
) (
    input  logic              clk,
    input  logic              reset,
    mod_wrap_counter_if.slave bus
);

    localparam logic [WIDTH-1:0] LP_MAX  = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] LP_ZERO = {WIDTH{1'b0}};
    // One extra bit so MODULUS == 2**WIDTH still compares correctly
    localparam logic [WIDTH:0]   LP_MOD  = (WIDTH + 1)'(MODULUS);

    logic [WIDTH-1:0] r_count;
    logic             r_wrap;
    logic             r_load_err;

    logic [WIDTH-1:0] w_count_nxt;
    logic             w_wrap_nxt;
    logic             w_load_err_nxt;
    logic             w_at_max;
    logic             w_at_zero;
    logic             w_load_ok;

    // End-of-range detection and terminal count for the next stage
    always_comb begin
        w_at_max  = (r_count == LP_MAX);
        w_at_zero = (r_count == LP_ZERO);
        w_load_ok = ({1'b0, bus.load_val} < LP_MOD);
        bus.tc    = bus.en & ((bus.up & w_at_max) | (~bus.up & w_at_zero));
    end

    // Next count with priority clr > load > en
    always_comb begin
        w_count_nxt    = r_count;
        w_wrap_nxt     = 1'b0;
        w_load_err_nxt = 1'b0;
        if (bus.clr) begin
            w_count_nxt = LP_ZERO;
        end else if (bus.load) begin
            if (w_load_ok) begin
                w_count_nxt = bus.load_val;
            end else begin
                w_count_nxt    = LP_ZERO;
                w_load_err_nxt = 1'b1;
            end
        end else if (bus.en) begin
            if (bus.up) begin
                if (w_at_max) begin
                    w_count_nxt = LP_ZERO;
                    w_wrap_nxt  = 1'b1;
                end else begin
                    w_count_nxt = r_count + WIDTH'(1);
                end
            end else begin
                if (w_at_zero) begin
                    w_count_nxt = LP_MAX;
                    w_wrap_nxt  = 1'b1;
                end else begin
                    w_count_nxt = r_count - WIDTH'(1);
                end
            end
        end else begin
            w_count_nxt = r_count;
        end
    end

    // Count, wrap pulse and load-error pulse registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count    <= LP_ZERO;
            r_wrap     <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_count    <= w_count_nxt;
            r_wrap     <= w_wrap_nxt;
            r_load_err <= w_load_err_nxt;
        end
    end

    assign bus.count    = r_count;
    assign bus.wrap     = r_wrap;
    assign bus.load_err = r_load_err;

`ifdef WRAP_COUNT_EN
    logic [7:0] r_wrap_cnt;

    // Saturating tally of wrap events, cleared together with the count
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wrap_cnt <= 8'h00;
        end else if (bus.clr) begin
            r_wrap_cnt <= 8'h00;
        end else if (w_wrap_nxt && (r_wrap_cnt != 8'hFF)) begin
            r_wrap_cnt <= r_wrap_cnt + 8'h01;
        end else begin
            r_wrap_cnt <= r_wrap_cnt;
        end
    end

    assign bus.wrap_cnt = r_wrap_cnt;
`endif

endmodule
